// File: rtl/can_rx.sv
// CAN 2.0A receiver: synchronized bus sampling with hard sync, destuffing,
// CRC-15 and form checks, ACK-slot request and received-frame outputs.
module can_rx #(
    parameter int CLKS_PER_BIT = 5000,
    parameter int SAMPLE_PT    = 3500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [10:0] address,
    output logic [63:0] data,
    output logic [3:0]  dlc,
    output logic        rtr,
    output logic        rx_valid,
    output logic        ack_tx,
    output logic        stuff_err,
    output logic        crc_err,
    output logic        form_err,
    output logic        busy
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] SP_CNT   = TW'(SAMPLE_PT);
    localparam logic [TW-1:0] LAST_CNT = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        S_WAIT_IDLE, S_IDLE, S_ID, S_CTRL, S_DATA, S_CRC,
        S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [2:0]    run_cnt_q, run_cnt_d;
    logic          run_val_q, run_val_d;
    logic [14:0]   crc_q, crc_d, crc_rx_q, crc_rx_d;
    logic [10:0]   id_s_q, id_s_d, address_q, address_d;
    logic          rtr_s_q, rtr_s_d, rtr_q, rtr_d;
    logic [3:0]    dlc_s_q, dlc_s_d, dlc_q, dlc_d, bytes_q, bytes_d;
    logic [63:0]   data_s_q, data_s_d, data_q, data_d;
    logic          rx_valid_q, rx_valid_d, ack_tx_q, ack_tx_d, busy_q, busy_d;
    logic          stuff_err_q, stuff_err_d, crc_err_q, crc_err_d, form_err_q, form_err_d;

    logic          fall, hunting, sync_now, sample, wrap, bit_v;
    logic          stuff_active, is_stuff, data_bit;
    logic [3:0]    dlc_full;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        crc_step = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    always_comb begin
        state_d     = state_q;
        rx_s1_d     = rx;
        rx_s2_d     = rx_s1_q;
        rx_prev_d   = rx_s2_q;
        cnt_d       = cnt_q;
        run_cnt_d   = run_cnt_q;
        run_val_d   = run_val_q;
        crc_d       = crc_q;
        crc_rx_d    = crc_rx_q;
        id_s_d      = id_s_q;
        rtr_s_d     = rtr_s_q;
        dlc_s_d     = dlc_s_q;
        bytes_d     = bytes_q;
        data_s_d    = data_s_q;
        address_d   = address_q;
        rtr_d       = rtr_q;
        dlc_d       = dlc_q;
        data_d      = data_q;
        ack_tx_d    = ack_tx_q;
        busy_d      = busy_q;
        rx_valid_d  = 1'b0;
        stuff_err_d = 1'b0;
        crc_err_d   = 1'b0;
        form_err_d  = 1'b0;
        dlc_full    = {dlc_s_q[2:0], rx_s2_q};

        bit_v    = rx_s2_q;
        fall     = rx_prev_q & ~rx_s2_q;
        hunting  = (state_q == S_WAIT_IDLE) || (state_q == S_ERROR);
        sync_now = fall && !hunting;
        // A hard sync always wins over a coincident sample point.
        sample   = (timer_q == SP_CNT) && !sync_now;
        if (sync_now || timer_q == LAST_CNT) timer_d = '0;
        else                                 timer_d = timer_q + 1'b1;
        wrap = (timer_d == '0);

        stuff_active = (state_q == S_ID) || (state_q == S_CTRL) || (state_q == S_DATA) ||
                       (state_q == S_CRC) || ((state_q == S_CRC_DEL) && (run_cnt_q == 3'd5));
        is_stuff = sample && stuff_active && (run_cnt_q == 3'd5);
        data_bit = sample && !is_stuff;

        if (sample && stuff_active) begin
            if (run_cnt_q == 3'd5 || bit_v != run_val_q) begin
                run_val_d = bit_v;
                run_cnt_d = 3'd1;
            end else begin
                run_cnt_d = run_cnt_q + 3'd1;
            end
        end
        if (is_stuff && bit_v == run_val_q) stuff_err_d = 1'b1;

        case (state_q)
            S_WAIT_IDLE, S_ERROR: if (sample) begin
                if (!bit_v)                cnt_d = '0;
                else if (cnt_q == 7'd10) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else                   cnt_d = cnt_q + 7'd1;
            end
            S_IDLE: if (sample && !bit_v) begin
                state_d   = S_ID;
                busy_d    = 1'b1;
                crc_d     = '0;
                data_s_d  = '0;
                id_s_d    = '0;
                cnt_d     = '0;
                run_val_d = 1'b0;
                run_cnt_d = 3'd1;
            end
            S_ID: if (data_bit) begin
                crc_d  = crc_step(crc_q, bit_v);
                id_s_d = {id_s_q[9:0], bit_v};
                cnt_d  = cnt_q + 7'd1;
                if (cnt_q == 7'd10) begin
                    state_d = S_CTRL;
                    cnt_d   = '0;
                end
            end
            S_CTRL: if (data_bit) begin
                crc_d = crc_step(crc_q, bit_v);
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'd0) rtr_s_d = bit_v;
                if (cnt_q == 7'd1 && bit_v) form_err_d = 1'b1;
                if (cnt_q >= 7'd3) dlc_s_d = dlc_full;
                if (cnt_q == 7'd6) begin
                    cnt_d   = '0;
                    bytes_d = rtr_s_q ? 4'd0 : ((dlc_full > 4'd8) ? 4'd8 : dlc_full);
                    state_d = (rtr_s_q || dlc_full == 4'd0) ? S_CRC : S_DATA;
                end
            end
            S_DATA: if (data_bit) begin
                crc_d = crc_step(crc_q, bit_v);
                data_s_d[6'd63 - cnt_q[5:0]] = bit_v;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == ({bytes_q, 3'b000} - 7'd1)) begin
                    state_d = S_CRC;
                    cnt_d   = '0;
                end
            end
            S_CRC: if (data_bit) begin
                crc_rx_d = {crc_rx_q[13:0], bit_v};
                cnt_d    = cnt_q + 7'd1;
                if (cnt_q == 7'd14) begin
                    state_d = S_CRC_DEL;
                    cnt_d   = '0;
                end
            end
            S_CRC_DEL: if (data_bit) begin
                if (!bit_v)                 form_err_d = 1'b1;
                else if (crc_rx_q == crc_q) state_d = S_ACK;
                else                        crc_err_d = 1'b1;
            end
            // ack_tx spans exactly the ACK slot: set on the first wrap, cleared on the next.
            S_ACK: if (wrap) begin
                if (!ack_tx_q) ack_tx_d = 1'b1;
                else begin
                    ack_tx_d = 1'b0;
                    state_d  = S_ACK_DEL;
                end
            end
            S_ACK_DEL: if (sample) begin
                if (!bit_v) form_err_d = 1'b1;
                else begin
                    state_d = S_EOF;
                    cnt_d   = '0;
                end
            end
            S_EOF: if (sample) begin
                if (!bit_v) form_err_d = 1'b1;
                else if (cnt_q == 7'd6) begin
                    address_d  = id_s_q;
                    rtr_d      = rtr_s_q;
                    dlc_d      = (dlc_s_q > 4'd8) ? 4'd8 : dlc_s_q;
                    data_d     = data_s_q;
                    rx_valid_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end else cnt_d = cnt_q + 7'd1;
            end
            default: state_d = S_WAIT_IDLE;
        endcase

        if (stuff_err_d || crc_err_d || form_err_d) begin
            state_d  = S_ERROR;
            busy_d   = 1'b0;
            ack_tx_d = 1'b0;
            cnt_d    = '0;
        end
    end

    // Synchronizer flops reset to recessive so no false edge follows reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT_IDLE;
            rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_prev_q <= 1'b1;
            timer_q <= '0;    cnt_q <= '0;      run_cnt_q <= '0;  run_val_q <= 1'b0;
            crc_q <= '0;      crc_rx_q <= '0;   id_s_q <= '0;     rtr_s_q <= 1'b0;
            dlc_s_q <= '0;    bytes_q <= '0;    data_s_q <= '0;   address_q <= '0;
            rtr_q <= 1'b0;    dlc_q <= '0;      data_q <= '0;     rx_valid_q <= 1'b0;
            ack_tx_q <= 1'b0; busy_q <= 1'b0;   stuff_err_q <= 1'b0;
            crc_err_q <= 1'b0; form_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_s1_q <= rx_s1_d;  rx_s2_q <= rx_s2_d;  rx_prev_q <= rx_prev_d;
            timer_q <= timer_d;  cnt_q <= cnt_d;      run_cnt_q <= run_cnt_d;  run_val_q <= run_val_d;
            crc_q <= crc_d;      crc_rx_q <= crc_rx_d; id_s_q <= id_s_d;      rtr_s_q <= rtr_s_d;
            dlc_s_q <= dlc_s_d;  bytes_q <= bytes_d;  data_s_q <= data_s_d;   address_q <= address_d;
            rtr_q <= rtr_d;      dlc_q <= dlc_d;      data_q <= data_d;       rx_valid_q <= rx_valid_d;
            ack_tx_q <= ack_tx_d; busy_q <= busy_d;   stuff_err_q <= stuff_err_d;
            crc_err_q <= crc_err_d; form_err_q <= form_err_d;
        end
    end

    assign address   = address_q;
    assign data      = data_q;
    assign dlc       = dlc_q;
    assign rtr       = rtr_q;
    assign rx_valid  = rx_valid_q;
    assign ack_tx    = ack_tx_q;
    assign stuff_err = stuff_err_q;
    assign crc_err   = crc_err_q;
    assign form_err  = form_err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_can_rx.sv
// Directed frame-level bench for can_rx: table of frames plus stuff-error and mid-frame reset sequences.
module tb_can_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic [10:0] address;
    logic [63:0] data;
    logic [3:0]  dlc;
    logic        rtr, rx_valid, ack_tx, stuff_err, crc_err, form_err, busy;

    can_rx #(.CLKS_PER_BIT(10), .SAMPLE_PT(6)) dut (
        .clk(clk), .rst(rst), .rx(rx), .address(address), .data(data), .dlc(dlc),
        .rtr(rtr), .rx_valid(rx_valid), .ack_tx(ack_tx), .stuff_err(stuff_err),
        .crc_err(crc_err), .form_err(form_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] dat;
        int          fault;      // 0 none, 1 CRC bit flipped, 2 dominant CRC delimiter, 3 dominant 3rd EOF bit
        int          exp_valid, exp_stuff, exp_crc, exp_form, exp_ack;
        logic [10:0] exp_addr;
        logic [63:0] exp_data;
        logic [3:0]  exp_dlc;
        logic        exp_rtr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0, stuff_cnt = 0, crc_cnt = 0, form_cnt = 0, ack_cnt = 0;
    int ack_run = 0, ack_last_run = 0;
    bit frame_q[$];
    vec_t vecs[7];
    vec_t v_7ff, v_abort;

    always @(negedge clk) begin
        valid_cnt <= valid_cnt + int'(rx_valid);
        stuff_cnt <= stuff_cnt + int'(stuff_err);
        crc_cnt   <= crc_cnt + int'(crc_err);
        form_cnt  <= form_cnt + int'(form_err);
        ack_cnt   <= ack_cnt + int'(ack_tx);
        if (ack_tx) ack_run <= ack_run + 1;
        else if (ack_run != 0) begin
            ack_last_run <= ack_run;
            ack_run      <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input bit b);
        rx = b;
        repeat (10) @(negedge clk);
    endtask

    task automatic build_frame(input vec_t v);
        bit raw[$];
        logic [14:0] c;
        int nb, run;
        bit last;
        frame_q.delete();
        nb = v.rtr ? 0 : ((v.dlc > 4'd8) ? 8 : int'(v.dlc));
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(v.id[i]);
        raw.push_back(v.rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(v.dlc[i]);
        for (int i = 0; i < nb * 8; i++) raw.push_back(v.dat[63 - i]);
        c = '0;
        foreach (raw[i]) c = {c[13:0], 1'b0} ^ (((raw[i] ^ c[14]) != 1'b0) ? 15'h4599 : 15'h0000);
        if (v.fault == 1) c[0] = ~c[0];
        for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
        run  = 0;
        last = 1'b1;
        foreach (raw[i]) begin
            frame_q.push_back(raw[i]);
            if (raw[i] == last) run++;
            else begin
                last = raw[i];
                run  = 1;
            end
            if (run == 5) begin
                frame_q.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        frame_q.push_back((v.fault == 2) ? 1'b0 : 1'b1);
        frame_q.push_back(1'b0);
        frame_q.push_back(1'b1);
        for (int i = 0; i < 7; i++) frame_q.push_back((v.fault == 3 && i == 2) ? 1'b0 : 1'b1);
    endtask

    task automatic check_after(input string tag, input vec_t v, input int v0, input int s0,
                               input int c0, input int f0, input int a0);
        chk({tag, " rx_valid"},  64'(valid_cnt - v0), 64'(v.exp_valid));
        chk({tag, " stuff_err"}, 64'(stuff_cnt - s0), 64'(v.exp_stuff));
        chk({tag, " crc_err"},   64'(crc_cnt - c0),   64'(v.exp_crc));
        chk({tag, " form_err"},  64'(form_cnt - f0),  64'(v.exp_form));
        chk({tag, " ack_clks"},  64'(ack_cnt - a0),   64'(v.exp_ack));
        if (v.exp_ack != 0) chk({tag, " ack_run"}, 64'(ack_last_run), 64'(v.exp_ack));
        chk({tag, " address"}, 64'(address), 64'(v.exp_addr));
        chk({tag, " data"},    data,         v.exp_data);
        chk({tag, " dlc"},     64'(dlc),     64'(v.exp_dlc));
        chk({tag, " rtr"},     64'(rtr),     64'(v.exp_rtr));
        chk({tag, " busy"},    64'(busy),    64'(0));
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int v0, s0, c0, f0, a0;
        v0 = valid_cnt; s0 = stuff_cnt; c0 = crc_cnt; f0 = form_cnt; a0 = ack_cnt;
        build_frame(v);
        repeat (11) send_bit(1'b1);
        foreach (frame_q[i]) send_bit(frame_q[i]);
        repeat (3) send_bit(1'b1);
        check_after(tag, v, v0, s0, c0, f0, a0);
        $display("%s: id=%03h dlc=%0d fault=%0d -> addr=%03h dlc=%0d rtr=%0d data=%016h",
                 tag, v.id, v.dlc, v.fault, address, dlc, rtr, data);
    endtask

    initial begin
        int v0, s0, c0, f0, a0;
        vec_t held;

        vecs[0] = '{11'h123, 1'b0, 4'd2,  64'hABCD_0000_0000_0000, 0, 1,0,0,0,10, 11'h123, 64'hABCD_0000_0000_0000, 4'd2, 1'b0};
        vecs[1] = '{11'h000, 1'b1, 4'd0,  64'h0,                   0, 1,0,0,0,10, 11'h000, 64'h0,                   4'd0, 1'b1};
        vecs[2] = '{11'h2A5, 1'b0, 4'd15, 64'h1122_3344_5566_7788, 0, 1,0,0,0,10, 11'h2A5, 64'h1122_3344_5566_7788, 4'd8, 1'b0};
        vecs[3] = '{11'h456, 1'b0, 4'd1,  64'h5A00_0000_0000_0000, 1, 0,0,1,0,0,  11'h2A5, 64'h1122_3344_5566_7788, 4'd8, 1'b0};
        vecs[4] = '{11'h456, 1'b0, 4'd1,  64'h5A00_0000_0000_0000, 2, 0,0,0,1,0,  11'h2A5, 64'h1122_3344_5566_7788, 4'd8, 1'b0};
        vecs[5] = '{11'h456, 1'b0, 4'd1,  64'h5A00_0000_0000_0000, 3, 0,0,0,1,10, 11'h2A5, 64'h1122_3344_5566_7788, 4'd8, 1'b0};
        vecs[6] = '{11'h456, 1'b0, 4'd1,  64'h5A00_0000_0000_0000, 0, 1,0,0,0,10, 11'h456, 64'h5A00_0000_0000_0000, 4'd1, 1'b0};
        v_abort = '{11'h3C3, 1'b0, 4'd4,  64'hDEAD_BEEF_0000_0000, 0, 0,0,0,0,0,  11'h000, 64'h0,                   4'd0, 1'b0};
        v_7ff   = '{11'h7FF, 1'b0, 4'd8,  64'h0102_0304_0506_0708, 0, 1,0,0,0,10, 11'h7FF, 64'h0102_0304_0506_0708, 4'd8, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset address", 64'(address), 64'(0));
        chk("reset data", data, 64'(0));
        chk("reset flags", 64'({rtr, rx_valid, ack_tx, stuff_err, crc_err, form_err, busy, dlc}), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Six dominant bits in the ID field, then a good frame.
        v0 = valid_cnt; s0 = stuff_cnt; c0 = crc_cnt; f0 = form_cnt; a0 = ack_cnt;
        held = vecs[6];
        held.exp_valid = 0; held.exp_stuff = 1; held.exp_ack = 0;
        repeat (11) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (6) send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        check_after("stuff", held, v0, s0, c0, f0, a0);
        $display("stuff: six dominant ID bits -> stuff_err count %0d", stuff_cnt - s0);
        run_vec("after_stuff", vecs[0]);

        // Reset in the middle of the data field.
        build_frame(v_abort);
        v0 = valid_cnt; s0 = stuff_cnt; c0 = crc_cnt; f0 = form_cnt; a0 = ack_cnt;
        repeat (11) send_bit(1'b1);
        foreach (frame_q[i]) begin
            if (i == 30) begin
                rx = frame_q[i];
                repeat (3) @(negedge clk);
                chk("busy before reset", 64'(busy), 64'(1));
                rst = 1'b0;
                #1;
                chk("mid reset address", 64'(address), 64'(0));
                chk("mid reset data", data, 64'(0));
                chk("mid reset flags", 64'({rtr, rx_valid, ack_tx, stuff_err, crc_err, form_err, busy, dlc}), 64'(0));
                repeat (3) @(negedge clk);
                rst = 1'b1;
                repeat (4) @(negedge clk);
            end else begin
                send_bit(frame_q[i]);
            end
        end
        repeat (3) send_bit(1'b1);
        check_after("aborted", v_abort, v0, s0, c0, f0, a0);
        $display("aborted: reset mid-DATA, frame ignored");
        run_vec("after_reset", v_7ff);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/can_rx.md
Name: can_rx

Overview:
- CAN 2.0A receiver; the receive-side counterpart of the transmit path. It samples the bus `rx` line and performs hard sync on SOF and on each recessive-to-dominant edge.
- It removes stuff bits, checks CRC-15 and frame form, and presents the received identifier, DLC and data to the host.
- It drives an ACK request during the ACK slot; the top level merges that request into the bus `tx` line.

Parameters:
- CLKS_PER_BIT, 5000: clk cycles per CAN bit time.
- SAMPLE_PT, 3500: bit-timer count at which rx is sampled (0..CLKS_PER_BIT-1).

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  raw CAN bus level (0 = dominant).
- address  output  11  received standard identifier.
- data  output  64  received data; byte 0 in [63:56], MSB first; unreceived bytes are 0.
- dlc  output  4  received DLC, clamped to 8.
- rtr  output  1  received RTR bit.
- rx_valid  output  1  one-clk pulse when a good frame completes.
- ack_tx  output  1  1 = drive dominant; asserted for the whole ACK slot bit time.
- stuff_err  output  1  one-clk error pulse.
- crc_err  output  1  one-clk error pulse.
- form_err  output  1  one-clk error pulse.
- busy  output  1  high from SOF until EOF or error.

Behaviour:
- Reset (rst=0) clears all outputs, counters, CRC and shift registers. State becomes WAIT_IDLE, regardless of any frame in progress.
- rx passes through a 2-flop synchronizer; all edge detection and sampling use the synchronized rx.
- Bit timer:
  - counts 0..CLKS_PER_BIT-1 and wraps;
  - reloads to 0 on a synchronized 1->0 edge in any state except WAIT_IDLE/ERROR;
  - the bit value is taken when timer == SAMPLE_PT.
- States: WAIT_IDLE, IDLE, ID, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, ERROR.
- WAIT_IDLE/ERROR: count consecutive recessive samples; after 11, go to IDLE. Any dominant sample restarts the count.
- IDLE:
  - a 1->0 edge resets the timer;
  - a dominant sample at SAMPLE_PT is SOF: clear CRC, clear data to 0, set busy=1, go to ID;
  - a recessive sample at SAMPLE_PT (glitch) returns to IDLE.
- Destuffing:
  - applies from SOF through the last CRC bit;
  - track run length of identical sampled bits, stuff bits included;
  - after 5 identical bits, the next sample is a stuff bit and is discarded;
  - if the stuff bit equals the run value: stuff_err pulse, go to ERROR.
- CRC-15:
  - polynomial 0x4599, initial value 0;
  - computed over destuffed bits from SOF through the last data bit.
- ID: shift in 11 bits MSB first, then go to CTRL.
- CTRL: receive RTR, IDE, r0, then DLC[3:0].
  - IDE=1: form_err, go to ERROR (extended frames are unsupported).
  - Byte count = 0 if RTR=1, else min(DLC,8).
  - Byte count 0 goes to CRC; otherwise go to DATA.
- DATA: shift 8×count bits into data[63:0] starting at bit 63, then go to CRC.
- CRC: receive 15 bits and compare with the computed CRC, then go to CRC_DEL.
- CRC_DEL:
  - a dominant sample gives form_err and goes to ERROR;
  - otherwise: on CRC match, assert ack_tx at the next timer wrap (start of ACK slot) and go to ACK;
  - on CRC mismatch: crc_err pulse, go to ERROR, ack_tx stays 0.
- ACK:
  - ack_tx stays 1 until the next timer wrap, then returns to 0;
  - the sample value is ignored;
  - next state is ACK_DEL.
- ACK_DEL: a dominant sample gives form_err and goes to ERROR.
- EOF: requires 7 recessive samples; any dominant sample gives form_err and goes to ERROR.
- Frame completion, at the sample of the 7th EOF bit, in the same clk:
  - update address, dlc, rtr and data;
  - pulse rx_valid;
  - set busy=0;
  - go to IDLE.
- Held values: outputs hold until the next good frame. Errors never modify address, data, dlc or rtr.
- Error pulses are mutually exclusive, one per frame. busy drops in the same cycle as the pulse.
- SOF edge to first sample latency is 2 + SAMPLE_PT clks.

Test Plan:
All tests use CLKS_PER_BIT=10 and SAMPLE_PT=6, with 11 recessive bits before each frame.
- Stuffed frame, ID 0x123, DLC 2, data AB CD, correct CRC -> ack_tx=1 for exactly 10 clks in the ACK slot; then rx_valid pulse, address=0x123, dlc=2, data=0xABCD000000000000, no error pulses.
- ID 0x000, DLC 0, RTR=1, with the stuff bits required after runs of 5 -> rx_valid, address=0x000, rtr=1, data=0. This confirms stuff bits are discarded.
- Six consecutive dominant bits inside the ID field -> stuff_err pulse, busy=0, no ack_tx or rx_valid. A following valid frame is received after 11 recessive bits.
- Valid frame with one CRC bit inverted -> crc_err pulse, ack_tx never asserted, previous address/data unchanged.
- Dominant CRC delimiter -> form_err. Separately, a dominant 3rd EOF bit -> form_err with no rx_valid.
- rst=0 mid-DATA for 3 clks -> all outputs 0 immediately. The block ignores the rest of the frame until 11 recessive bits, then correctly receives ID 0x7FF, DLC 8, data 0x0102030405060708.
